// File: rtl/illm_d1_join_ctl.sv
// illm_d1_join_ctl: joins the heads of the NSTR page input queues so that
// every stream advances together.
// Tokens are consumed only when all heads are valid and downstream is not
// stalled. The controller sequences a frame from go to a joint EOS and traps
// EOS misalignment between streams in a sticky ERR state.
// Optional watchdog: define ILLM_JOIN_TMO_EN to add the partial-join timeout
// flag (tmo). Without it, tmo is tied low.
module illm_d1_join_ctl #(
  parameter int NSTR = 8,
  parameter int CW   = 16,
  parameter int TMO  = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            go,
  input  logic            clr,
  input  logic [NSTR-1:0] q_v,
  input  logic [NSTR-1:0] q_e,
  output logic [NSTR-1:0] q_b,
  input  logic            dn_b,
  output logic            fire,
  output logic            eos_fire,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [CW-1:0]   fire_cnt,
  output logic            tmo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   fire_cnt_r, fire_cnt_s;
  logic            busy_r, done_r, err_r;
  logic            all_v_s, all_d_s, all_e_s, mix_s;
  logic            fire_s, eos_fire_s;

  // Join conditions on the queue heads
  assign all_v_s    = &q_v;
  assign all_d_s    = all_v_s & ~(|q_e);
  assign all_e_s    = all_v_s & (&q_e);
  assign mix_s      = all_v_s & (|q_e) & ~(&q_e);
  assign fire_s     = (state_r == RUN) & all_d_s & ~dn_b;
  assign eos_fire_s = (state_r == RUN) & all_e_s & ~dn_b;

  assign fire     = fire_s;
  assign eos_fire = eos_fire_s;
  // Hold every queue unless a joint consume happens this cycle
  assign q_b      = {NSTR{~(fire_s | eos_fire_s)}};
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign fire_cnt = fire_cnt_r;

  // Next-state and firing counter update
  always_comb begin
    state_s    = state_r;
    fire_cnt_s = fire_cnt_r;
    case (state_r)
      IDLE, DONE: begin
        if (go) begin
          state_s    = RUN;
          fire_cnt_s = {CW{1'b0}};
        end else begin
          state_s    = state_r;
        end
      end
      RUN: begin
        if (mix_s) begin
          state_s = ERR;
        end else if (eos_fire_s) begin
          state_s = DONE;
        end else if (fire_s) begin
          fire_cnt_s = fire_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          state_s = RUN;
        end
      end
      ERR: begin
        if (clr) begin
          state_s = IDLE;
        end else begin
          state_s = ERR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counter and registered status flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      fire_cnt_r <= {CW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      fire_cnt_r <= fire_cnt_s;
      busy_r     <= (state_s == RUN);
      done_r     <= (state_s == DONE);
      err_r      <= (state_s == ERR);
    end
  end

`ifdef ILLM_JOIN_TMO_EN
  localparam logic [7:0] TMO_L = 8'(TMO);

  logic [7:0] wd_r;
  logic       tmo_r;
  logic       wd_inc_s;

  // Watchdog counts cycles stuck on a partial join or a stalled full join
  assign wd_inc_s = (state_r == RUN) &
                    (((|q_v) & ~all_v_s) | (all_v_s & dn_b));

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_r  <= 8'd0;
      tmo_r <= 1'b0;
    end else begin
      if (fire_s | eos_fire_s | ~(|q_v) | (state_r != RUN)) begin
        wd_r <= 8'd0;
      end else if (wd_inc_s && (wd_r != TMO_L)) begin
        wd_r <= wd_r + 8'd1;
      end else begin
        wd_r <= wd_r;
      end
      if (clr) begin
        tmo_r <= 1'b0;
      end else if (wd_r == TMO_L) begin
        tmo_r <= 1'b1;
      end else begin
        tmo_r <= tmo_r;
      end
    end
  end

  assign tmo = tmo_r;
`else
  assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_illm_d1_join_ctl.sv
// Directed testbench for illm_d1_join_ctl.
module tb_illm_d1_join_ctl;

  logic        clock;
  logic        reset;
  logic        go;
  logic        clr;
  logic [7:0]  q_v;
  logic [7:0]  q_e;
  logic [7:0]  q_b;
  logic        dn_b;
  logic        fire;
  logic        eos_fire;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] fire_cnt;
  logic        tmo;

  int n_run;
  int n_fail;

  illm_d1_join_ctl dut (
    .clock    (clock),
    .reset    (reset),
    .go       (go),
    .clr      (clr),
    .q_v      (q_v),
    .q_e      (q_e),
    .q_b      (q_b),
    .dn_b     (dn_b),
    .fire     (fire),
    .eos_fire (eos_fire),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .fire_cnt (fire_cnt),
    .tmo      (tmo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b0;
    go     = 1'b0;
    clr    = 1'b0;
    q_v    = 8'h00;
    q_e    = 8'h00;
    dn_b   = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err",  {31'd0, err},  32'd0);
    check("rst_cnt",  {16'd0, fire_cnt}, 32'd0);
    check("rst_qb",   {24'd0, q_b},  32'h0000_00ff);
    check("rst_tmo",  {31'd0, tmo},  32'd0);
    reset = 1'b1;
    tick();

    // 1: ten back-to-back firings
    go = 1'b1;
    tick();
    go = 1'b0;
    check("t1_busy0", {31'd0, busy}, 32'd1);
    check("t1_cnt0", {16'd0, fire_cnt}, 32'd0);
    q_v = 8'hff;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t1_fire", {31'd0, fire}, 32'd1);
      check("t1_qb", {24'd0, q_b}, 32'd0);
      tick();
    end
    check("t1_cnt", {16'd0, fire_cnt}, 32'd10);
    check("t1_busy", {31'd0, busy}, 32'd1);

    // 2: one missing stream holds every queue
    q_v = 8'h7f;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_fire", {31'd0, fire}, 32'd0);
      check("t2_qb", {24'd0, q_b}, 32'h0000_00ff);
      tick();
    end
    check("t2_cnt_hold", {16'd0, fire_cnt}, 32'd10);
    q_v = 8'hff;
    #1;
    check("t2_fire6", {31'd0, fire}, 32'd1);
    tick();
    q_v = 8'h00;
    check("t2_cnt", {16'd0, fire_cnt}, 32'd11);

    // 3: stalled joint EOS, then restart
    do_reset();
    go = 1'b1;
    tick();
    go  = 1'b0;
    q_v = 8'hff;
    for (int i = 0; i < 3; i++) tick();
    q_e  = 8'hff;
    dn_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t3_stall_eos", {31'd0, eos_fire}, 32'd0);
      check("t3_stall_qb", {24'd0, q_b}, 32'h0000_00ff);
      tick();
    end
    dn_b = 1'b0;
    #1;
    check("t3_eos", {31'd0, eos_fire}, 32'd1);
    check("t3_eos_fire", {31'd0, fire}, 32'd0);
    check("t3_eos_qb", {24'd0, q_b}, 32'd0);
    tick();
    q_v = 8'h00;
    q_e = 8'h00;
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_cnt", {16'd0, fire_cnt}, 32'd3);
    check("t3_done_qb", {24'd0, q_b}, 32'h0000_00ff);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("t3_rebusy", {31'd0, busy}, 32'd1);
    check("t3_recnt", {16'd0, fire_cnt}, 32'd0);
    check("t3_redone", {31'd0, done}, 32'd0);

    // 4: misaligned EOS traps in ERR until clr
    q_v = 8'hff;
    q_e = 8'h01;
    #1;
    check("t4_mix_fire", {31'd0, fire}, 32'd0);
    check("t4_mix_eos", {31'd0, eos_fire}, 32'd0);
    check("t4_mix_qb", {24'd0, q_b}, 32'h0000_00ff);
    tick();
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    go  = 1'b1;
    q_e = 8'h00;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t4_err_hold", {31'd0, err}, 32'd1);
      check("t4_qb_hold", {24'd0, q_b}, 32'h0000_00ff);
    end
    go  = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t4_clr_err", {31'd0, err}, 32'd0);
    check("t4_clr_busy", {31'd0, busy}, 32'd0);
    check("t4_idle_qb", {24'd0, q_b}, 32'h0000_00ff);

    // 5: asynchronous reset mid-frame
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("t5_cnt7", {16'd0, fire_cnt}, 32'd7);
    reset = 1'b0;
    #1;
    check("t5_cnt", {16'd0, fire_cnt}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_fire", {31'd0, fire}, 32'd0);
    check("t5_qb", {24'd0, q_b}, 32'h0000_00ff);
    reset = 1'b1;
    q_v   = 8'h00;
    tick();

    // 6: watchdog on a partial join
    go = 1'b1;
    tick();
    go  = 1'b0;
    q_v = 8'hfe;
    for (int i = 0; i < 250; i++) tick();
    check("t6_tmo_early", {31'd0, tmo}, 32'd0);
    for (int i = 0; i < 50; i++) tick();
`ifdef ILLM_JOIN_TMO_EN
    check("t6_tmo", {31'd0, tmo}, 32'd1);
`else
    check("t6_tmo", {31'd0, tmo}, 32'd0);
`endif
    check("t6_busy", {31'd0, busy}, 32'd1);
    check("t6_qb", {24'd0, q_b}, 32'h0000_00ff);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
